// File: rtl/uart_word_bridge_pkg.sv
// Shared encodings for the UART word bridge: FSM state codes and the default word size.
package uart_word_bridge_pkg;

    localparam int WORD_BYTES_DEFAULT = 4;

    localparam logic [1:0] RX_IDLE = 2'd0;
    localparam logic [1:0] RX_POP  = 2'd1;
    localparam logic [1:0] RX_GAP  = 2'd2;

    localparam logic [1:0] TX_IDLE = 2'd0;
    localparam logic [1:0] TX_LOAD = 2'd1;
    localparam logic [1:0] TX_WAIT = 2'd2;

endpackage

// File: rtl/uart_word_bridge_tx.sv
// TX half of the word bridge: latches a word and feeds it byte by byte (LSB first)
// to the UART transmitter, advancing only on a fresh rising edge of tx_done.
module uart_word_bridge_tx
    import uart_word_bridge_pkg::*;
#(
    parameter int WORD_BYTES = WORD_BYTES_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [8*WORD_BYTES-1:0] word_in,
    input  logic                    word_send,
    input  logic                    tx_done,
    output logic [7:0]              tx_data,
    output logic                    tx_start,
    output logic                    tx_busy
);

    localparam int IDX_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_BYTES - 1);

    logic [1:0]              r_state;
    logic [8*WORD_BYTES-1:0] r_word;
    logic [IDX_W-1:0]        r_idx;
    logic [7:0]              r_tx_data;
    logic                    r_done_q;
    logic                    w_done_rise;
    logic [IDX_W-1:0]        w_idx_next;

    // A level already high when TX_WAIT is entered has r_done_q set, so it never counts.
    assign w_done_rise = tx_done & ~r_done_q;
    assign w_idx_next  = r_idx + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= TX_IDLE;
            r_word    <= '0;
            r_idx     <= '0;
            r_tx_data <= '0;
            r_done_q  <= 1'b0;
        end else begin
            r_done_q <= tx_done;
            case (r_state)
                TX_IDLE: begin
                    if (word_send) begin
                        r_word    <= word_in;
                        r_idx     <= '0;
                        r_tx_data <= word_in[7:0];
                        r_state   <= TX_LOAD;
                    end
                end
                TX_LOAD: r_state <= TX_WAIT;
                TX_WAIT: begin
                    if (w_done_rise) begin
                        r_idx <= w_idx_next;
                        if (r_idx == LAST_IDX) begin
                            r_state <= TX_IDLE;
                        end else begin
                            r_tx_data <= r_word[8*w_idx_next +: 8];
                            r_state   <= TX_LOAD;
                        end
                    end
                end
                default: r_state <= TX_IDLE;
            endcase
        end
    end

    assign tx_data  = r_tx_data;
    assign tx_start = (r_state == TX_LOAD);
    assign tx_busy  = (r_state != TX_IDLE);

endmodule

// File: rtl/uart_word_bridge.sv
// Bridges the UART byte FIFO/transmitter to 32-bit words: little-endian RX word assembly
// with a byte-gap timeout, and a TX path that serialises a word into four bytes.
module uart_word_bridge
    import uart_word_bridge_pkg::*;
#(
    parameter int WORD_BYTES     = WORD_BYTES_DEFAULT,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int CNT_W          = 20
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [7:0]              rx_data,
    input  logic                    rx_available,
    output logic                    rx_read,
    output logic [7:0]              tx_data,
    output logic                    tx_start,
    input  logic                    tx_done,
    output logic [8*WORD_BYTES-1:0] word_out,
    output logic                    word_valid,
    output logic                    rx_timeout_err,
    input  logic [8*WORD_BYTES-1:0] word_in,
    input  logic                    word_send,
    output logic                    tx_busy
);

    localparam int WORD_W = 8 * WORD_BYTES;
    localparam int IDX_W  = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_BYTES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]        r_rx_state;
    logic [IDX_W-1:0]  r_byte_cnt;
    logic [WORD_W-1:0] r_shift;
    logic [WORD_W-1:0] r_word_out;
    logic [CNT_W-1:0]  r_tmo_cnt;
    logic              r_word_valid;
    logic              r_timeout_err;
    logic [WORD_W-1:0] w_full_word;
    logic              w_popping;

    assign w_popping = (r_rx_state == RX_POP);

    // Shift register with the byte being popped merged into its lane.
    always_comb begin
        w_full_word = r_shift;
        w_full_word[8*r_byte_cnt +: 8] = rx_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rx_state    <= RX_IDLE;
            r_byte_cnt    <= '0;
            r_shift       <= '0;
            r_word_out    <= '0;
            r_tmo_cnt     <= '0;
            r_word_valid  <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_word_valid  <= 1'b0;
            r_timeout_err <= 1'b0;
            case (r_rx_state)
                RX_IDLE: if (rx_available) r_rx_state <= RX_POP;
                RX_POP: begin
                    r_shift    <= w_full_word;
                    r_rx_state <= RX_GAP;
                    if (r_byte_cnt == LAST_IDX) begin
                        r_byte_cnt   <= '0;
                        r_word_out   <= w_full_word;
                        r_word_valid <= 1'b1;
                    end else begin
                        r_byte_cnt <= r_byte_cnt + 1'b1;
                    end
                end
                // The empty flag has settled by the end of the gap cycle, so a waiting
                // byte is popped straight away, giving one pop every two cycles.
                RX_GAP: r_rx_state <= rx_available ? RX_POP : RX_IDLE;
                default: r_rx_state <= RX_IDLE;
            endcase

            if (w_popping || (r_byte_cnt == '0)) begin
                r_tmo_cnt <= '0;
            end else if (!rx_available) begin
                if (r_tmo_cnt == TMO_LAST) begin
                    r_tmo_cnt     <= '0;
                    r_byte_cnt    <= '0;
                    r_timeout_err <= 1'b1;
                end else begin
                    r_tmo_cnt <= r_tmo_cnt + 1'b1;
                end
            end
        end
    end

    assign rx_read        = w_popping;
    assign word_out       = r_word_out;
    assign word_valid     = r_word_valid;
    assign rx_timeout_err = r_timeout_err;

    uart_word_bridge_tx #(
        .WORD_BYTES(WORD_BYTES)
    ) u_tx (
        .clk      (clk),
        .rst_n    (reset),
        .word_in  (word_in),
        .word_send(word_send),
        .tx_done  (tx_done),
        .tx_data  (tx_data),
        .tx_start (tx_start),
        .tx_busy  (tx_busy)
    );

endmodule

// File: tb/tb_uart_word_bridge.sv
// Bench for uart_word_bridge: models the RX FIFO and the UART transmitter around the bridge.
module tb_uart_word_bridge;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_available;
    logic        rx_read;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_done;
    logic [31:0] word_out;
    logic        word_valid;
    logic        rx_timeout_err;
    logic [31:0] word_in;
    logic        word_send;
    logic        tx_busy;

    always #5 clk = ~clk;

    uart_word_bridge #(
        .WORD_BYTES(4),
        .TIMEOUT_CYCLES(TMO),
        .CNT_W(5)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .rx_data       (rx_data),
        .rx_available  (rx_available),
        .rx_read       (rx_read),
        .tx_data       (tx_data),
        .tx_start      (tx_start),
        .tx_done       (tx_done),
        .word_out      (word_out),
        .word_valid    (word_valid),
        .rx_timeout_err(rx_timeout_err),
        .word_in       (word_in),
        .word_send     (word_send),
        .tx_busy       (tx_busy)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [7:0]  fifo_q[$];
    logic [31:0] exp_word_q[$];
    logic [7:0]  exp_tx_q[$];
    int          rd_cyc_q[$];

    int n_rd = 0, handled_rd = 0, n_tmo = 0, last_tmo_cyc = 0;
    int n_start = 0, handled_start = 0, n_done_rise = 0, last_rise_cyc = 0, fall_cyc = 0;
    int n_unexp_words = 0, n_unexp_tx = 0;
    logic [7:0] last_start_byte = 8'h00;
    logic prev_done_s = 1'b0, prev_busy_s = 1'b0;

    bit auto_done = 1'b1;
    bit manual_done = 1'b0;
    int done_delay = 100;
    int done_cnt = 0;
    bit done_lvl = 1'b0, done_hi = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // FIFO model and transmitter model, updated just after each rising edge.
    always @(posedge clk) begin
        cyc++;
        #1;
        while (handled_rd < n_rd) begin
            handled_rd++;
            if (fifo_q.size() > 0) void'(fifo_q.pop_front());
        end
        rx_available = (fifo_q.size() != 0);
        rx_data      = rx_available ? fifo_q[0] : 8'h00;
        if (handled_start != n_start) begin
            handled_start = n_start;
            if (auto_done) done_cnt = done_delay;
        end
        if (done_hi) begin
            done_hi  = 1'b0;
            done_lvl = 1'b0;
        end
        if (done_cnt > 0) begin
            done_cnt--;
            if (done_cnt == 0) begin
                done_lvl = 1'b1;
                done_hi  = 1'b1;
            end
        end
        tx_done = auto_done ? done_lvl : manual_done;
    end

    // Scoreboard / monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (reset) begin
            if (word_valid) begin
                if (exp_word_q.size() == 0) n_unexp_words++;
                else check("rx_word", word_out, exp_word_q.pop_front());
            end
            if (rx_timeout_err) begin
                n_tmo++;
                last_tmo_cyc = cyc;
            end
            if (rx_read) begin
                n_rd++;
                rd_cyc_q.push_back(cyc);
            end
            if (tx_start) begin
                n_start++;
                last_start_byte = tx_data;
                if (exp_tx_q.size() == 0) n_unexp_tx++;
                else check("tx_byte", {24'h0, tx_data}, {24'h0, exp_tx_q.pop_front()});
            end else if (tx_busy) begin
                check("tx_data_stable", {24'h0, tx_data}, {24'h0, last_start_byte});
            end
            if (tx_done && !prev_done_s) begin
                n_done_rise++;
                last_rise_cyc = cyc;
            end
            if (prev_busy_s && !tx_busy) fall_cyc = cyc;
            prev_done_s = tx_done;
            prev_busy_s = tx_busy;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic push_bytes(input logic [31:0] w, input int n);
        for (int i = 0; i < n; i++) fifo_q.push_back(w[8*i +: 8]);
    endtask

    task automatic wait_rx_drained();
        int k = 0;
        while (fifo_q.size() != 0 && k < 500) begin
            tick(1);
            k++;
        end
        if (k >= 500) check("rx_drain_bound", fifo_q.size(), 0);
        tick(4);
    endtask

    task automatic wait_tx_idle();
        int k = 0;
        while (tx_busy && k < 3000) begin
            tick(1);
            k++;
        end
        if (k >= 3000) check("tx_idle_bound", {31'h0, tx_busy}, 0);
    endtask

    task automatic send_word(input logic [31:0] w);
        word_in   = w;
        word_send = 1'b1;
        tick(1);
        word_send = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rx_read"}, {31'h0, rx_read}, 0);
        check({tag, "_tx_start"}, {31'h0, tx_start}, 0);
        check({tag, "_word_valid"}, {31'h0, word_valid}, 0);
        check({tag, "_timeout_err"}, {31'h0, rx_timeout_err}, 0);
        check({tag, "_tx_busy"}, {31'h0, tx_busy}, 0);
        check({tag, "_word_out"}, word_out, 0);
        check({tag, "_tx_data"}, {24'h0, tx_data}, 0);
    endtask

    typedef struct {
        logic [31:0] bytes_le;
        int          n;
        logic [31:0] exp_word;
        int          exp_tmo;
    } rx_vec_t;

    typedef struct {
        logic [31:0] w;
        int          delay;
        logic [31:0] exp_seq;
        bit          busy_poke;
    } tx_vec_t;

    rx_vec_t rx_vec[7];
    tx_vec_t tx_vec[3];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int rd0, tmo0, s0, r0, t0, d, n;
        bit trunc;
        logic [7:0] b[4];
        logic [31:0] rexp, tw, last_good;

        rx_vec[0] = '{32'h12345678, 4, 32'h12345678, 0};
        rx_vec[1] = '{32'h000000AA, 1, 32'h12345678, 1};
        rx_vec[2] = '{32'h04030201, 4, 32'h04030201, 0};
        rx_vec[3] = '{32'h0000BBCC, 2, 32'h04030201, 1};
        rx_vec[4] = '{32'h00DDEEFF, 3, 32'h04030201, 1};
        rx_vec[5] = '{32'hFFFFFFFF, 4, 32'hFFFFFFFF, 0};
        rx_vec[6] = '{32'h00000000, 4, 32'h00000000, 0};

        tx_vec[0] = '{32'hDEADBEEF, 100, 32'hEFBEADDE, 1'b1};
        tx_vec[1] = '{32'h01234567, 5,   32'h67452301, 1'b0};
        tx_vec[2] = '{32'h80000001, 1,   32'h01000080, 1'b0};

        reset = 1'b0;
        rx_data = 8'h00;
        rx_available = 1'b0;
        tx_done = 1'b0;
        word_in = 32'h0;
        word_send = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk);
        #2;
        reset = 1'b1;
        tick(3);

        for (int v = 0; v < 7; v++) begin
            rd0  = n_rd;
            tmo0 = n_tmo;
            rd_cyc_q.delete();
            if (rx_vec[v].n == 4) exp_word_q.push_back(rx_vec[v].exp_word);
            push_bytes(rx_vec[v].bytes_le, rx_vec[v].n);
            wait_rx_drained();
            if (rx_vec[v].n < 4) tick(3 * TMO);
            check($sformatf("rx%0d_word_out", v), word_out, rx_vec[v].exp_word);
            check($sformatf("rx%0d_reads", v), n_rd - rd0, rx_vec[v].n);
            check($sformatf("rx%0d_timeouts", v), n_tmo - tmo0, rx_vec[v].exp_tmo);
            for (int i = 1; i < rd_cyc_q.size(); i++)
                check($sformatf("rx%0d_pop_spacing", v), rd_cyc_q[i] - rd_cyc_q[i-1], 2);
            if (rx_vec[v].exp_tmo != 0 && rd_cyc_q.size() > 0) begin
                d = last_tmo_cyc - rd_cyc_q[rd_cyc_q.size()-1];
                check($sformatf("rx%0d_tmo_latency_in_range", v), (d >= TMO && d <= TMO + 2), 1);
            end
        end

        for (int v = 0; v < 3; v++) begin
            for (int i = 0; i < 4; i++) exp_tx_q.push_back(tx_vec[v].exp_seq[31-8*i -: 8]);
            s0 = n_start;
            r0 = n_done_rise;
            done_delay = tx_vec[v].delay;
            send_word(tx_vec[v].w);
            if (tx_vec[v].busy_poke) begin
                tick(20);
                word_in   = 32'h11111111;
                word_send = 1'b1;
                tick(3);
                word_send = 1'b0;
            end
            wait_tx_idle();
            tick(2);
            check($sformatf("tx%0d_starts", v), n_start - s0, 4);
            check($sformatf("tx%0d_done_edges", v), n_done_rise - r0, 4);
            check($sformatf("tx%0d_busy_fall", v), fall_cyc, last_rise_cyc + 1);
            check($sformatf("tx%0d_bytes_left", v), exp_tx_q.size(), 0);
        end

        // tx_done held high from before the start: only a fresh edge may advance.
        auto_done   = 1'b0;
        manual_done = 1'b1;
        tick(3);
        tw = 32'h5AC33C96;
        for (int i = 0; i < 4; i++) exp_tx_q.push_back(8'((tw >> (8*i)) & 32'hFF));
        s0 = n_start;
        send_word(tw);
        tick(10);
        check("hold_high_no_advance", n_start - s0, 1);
        manual_done = 1'b0;
        tick(3);
        check("hold_low_no_advance", n_start - s0, 1);
        manual_done = 1'b1;
        tick(4);
        check("hold_reedge_advance", n_start - s0, 2);
        repeat (2) begin
            manual_done = 1'b0;
            tick(3);
            manual_done = 1'b1;
            tick(4);
        end
        check("hold_all_starts", n_start - s0, 4);
        manual_done = 1'b0;
        tick(3);
        manual_done = 1'b1;
        tick(4);
        check("hold_busy_end", {31'h0, tx_busy}, 0);
        manual_done = 1'b0;
        tick(3);
        auto_done = 1'b1;

        // Reset in the middle of an RX word and a TX word.
        done_delay = 100;
        exp_tx_q.push_back(8'h0D);
        s0 = n_start;
        send_word(32'hCAFEF00D);
        push_bytes(32'h00006655, 2);
        tick(10);
        check("rst_pre_starts", n_start - s0, 1);
        reset = 1'b0;
        @(negedge clk);
        check_all_zero("midrst");
        @(posedge clk);
        #2;
        reset = 1'b1;
        fifo_q.delete();
        s0 = n_start;
        t0 = n_tmo;
        tick(150);
        check("rst_no_tx_restart", n_start - s0, 0);
        check("rst_tx_idle", {31'h0, tx_busy}, 0);
        exp_word_q.push_back(32'h0D0C0B0A);
        push_bytes(32'h0D0C0B0A, 4);
        wait_rx_drained();
        check("rst_word_out", word_out, 32'h0D0C0B0A);
        check("rst_no_timeout", n_tmo - t0, 0);
        last_good = 32'h0D0C0B0A;

        // Random concurrent RX and TX traffic against the reference model.
        for (int it = 0; it < 12; it++) begin
            trunc = ($urandom_range(0, 3) == 0);
            n = trunc ? $urandom_range(1, 3) : 4;
            for (int i = 0; i < 4; i++) b[i] = 8'($urandom_range(0, 255));
            rexp = 32'(b[0]) + 32'(b[1]) * 256 + 32'(b[2]) * 65536 + 32'(b[3]) * 16777216;
            if (!trunc) begin
                exp_word_q.push_back(rexp);
                last_good = rexp;
            end
            tw = $urandom;
            for (int i = 0; i < 4; i++) exp_tx_q.push_back(8'((tw >> (8*i)) & 32'hFF));
            done_delay = $urandom_range(1, 20);
            s0 = n_start;
            t0 = n_tmo;
            send_word(tw);
            for (int i = 0; i < n; i++) begin
                fifo_q.push_back(b[i]);
                tick($urandom_range(0, 6));
            end
            wait_rx_drained();
            if (trunc) tick(3 * TMO);
            wait_tx_idle();
            tick(2);
            check($sformatf("rand%0d_word_out", it), word_out, last_good);
            check($sformatf("rand%0d_timeouts", it), n_tmo - t0, trunc ? 1 : 0);
            check($sformatf("rand%0d_tx_starts", it), n_start - s0, 4);
        end

        tick(5);
        check("unexpected_words", n_unexp_words, 0);
        check("unexpected_tx_bytes", n_unexp_tx, 0);
        check("words_outstanding", exp_word_q.size(), 0);
        check("tx_bytes_outstanding", exp_tx_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
